float_round: RTL and testbench

Final rounding and packing stage of the FPU. It accepts unrounded results from the arithmetic units (sqrt, div, add, mul) and turns them into IEEE-754 binary32 words with RISC-V fflags:
- takes a normalized mantissa with round/sticky bits, a signed unbiased exponent, the sign and the rounding mode;
- denormalizes tiny results, applies the rounding mode, handles mantissa carry-out and overflow;
- packs the result and emits the accumulated exception flags through a 2-stage valid/ready pipeline.

---
 rtl/float_round_pkg.sv | 49 ++++
 rtl/float_round_if.sv | 34 +++
 rtl/float_round_denorm.sv | 21 ++
 rtl/float_round.sv | 160 ++++++++++++++++
 tb/tb_float_round.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/float_round_pkg.sv
// Shared types and constants for the binary32 rounding/packing stage.
// Rounding-mode encoding, fflags bit positions and the stage-1 payload.
package float_round_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;
  localparam int FLAGS_W = 5;

  localparam int          BIAS      = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [23:0]        man;
    logic               r;
    logic               s;
    logic signed [10:0] e;
    logic               sgn;
    rm_e                rm;
    logic               skip;
    logic               iv;
    logic               dz;
    logic               tiny;
  } s1_t;

  // Reserved encodings 101..111 behave as round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] rm);
    case (rm)
      3'b000:  return RM_RNE;
      3'b001:  return RM_RTZ;
      3'b010:  return RM_RDN;
      3'b011:  return RM_RUP;
      3'b100:  return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/float_round_if.sv
// Handshake and data bundle between the arithmetic units, the rounder and
// the downstream consumer. master = upstream/downstream side, slave = rounder.
interface float_round_if;
  import float_round_pkg::*;

  logic               valid_in;
  logic               ready_out;
  logic               valid_out;
  logic               ready_in;
  logic [23:0]        man_in;
  logic [9:0]         exp_in;
  logic               sgn_in;
  logic               round_bit;
  logic               sticky_bit;
  logic               skip_round;
  logic               IV;
  logic               DZ;
  logic [2:0]         rm;
  logic [31:0]        float_out;
  logic [FLAGS_W-1:0] fflags;

  modport master (
    output valid_in, ready_in, man_in, exp_in, sgn_in, round_bit, sticky_bit,
           skip_round, IV, DZ, rm,
    input  ready_out, valid_out, float_out, fflags
  );

  modport slave (
    input  valid_in, ready_in, man_in, exp_in, sgn_in, round_bit, sticky_bit,
           skip_round, IV, DZ, rm,
    output ready_out, valid_out, float_out, fflags
  );

endinterface

// File: rtl/float_round_denorm.sv
// float_denorm: combinational right shifter that folds every bit shifted out
// into the LSB (sticky). Used only when FLOAT_ROUND_SUBNORMAL_EN is defined.
module float_denorm (
  input  logic [25:0] data_in,
  input  logic [4:0]  shamt,
  output logic [25:0] data_out
);

  logic [25:0] shifted;
  logic        lost;

  always_comb begin
    shifted = data_in >> shamt;
    lost    = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (i < 32'(shamt)) lost = lost | data_in[i];
    end
    data_out = {shifted[25:1], shifted[0] | lost};
  end

endmodule

// File: rtl/float_round.sv
// Final IEEE-754 binary32 round-and-pack stage with RISC-V fflags, 2-stage
// valid/ready pipeline. FLOAT_ROUND_SUBNORMAL_EN enables gradual underflow.
module float_round
  import float_round_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  float_round_if.slave bus
);

  function automatic logic round_inc(input rm_e rm, input logic sgn,
                                     input logic lsb, input logic r,
                                     input logic s);
    case (rm)
      RM_RNE:  return r & (s | lsb);
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sgn & (r | s);
      RM_RUP:  return !sgn & (r | s);
      RM_RMM:  return r;
      default: return r & (s | lsb);
    endcase
  endfunction

  // Directed modes that round away from the overflowing side saturate.
  function automatic logic ovf_to_max(input rm_e rm, input logic sgn);
    return (rm == RM_RTZ) || (rm == RM_RDN && !sgn) || (rm == RM_RUP && sgn);
  endfunction

  logic               adv;
  logic               vld_p1;
  logic               vld_p2;
  s1_t                s1_d;
  s1_t                s1_p1;
  logic signed [10:0] e_bias;
  logic               tiny_in;
  logic [31:0]        float_d;
  logic [31:0]        float_p2;
  logic [FLAGS_W-1:0] flags_d;
  logic [FLAGS_W-1:0] flags_p2;

  assign adv           = !vld_p2 || bus.ready_in;
  assign bus.ready_out = adv;
  assign bus.valid_out = vld_p2;
  assign bus.float_out = float_p2;
  assign bus.fflags    = flags_p2;

  // ---- stage 1: bias and denormalize ----
  always_comb begin
    e_bias  = $signed({bus.exp_in[9], bus.exp_in}) + $signed(11'(BIAS));
    tiny_in = !bus.skip_round && (e_bias <= 11'sd0);
  end

`ifdef FLOAT_ROUND_SUBNORMAL_EN
  logic [10:0] sh_full;
  logic [4:0]  shamt;
  logic [25:0] dn_out;

  always_comb begin
    sh_full = 11'sd1 - e_bias;
    shamt   = (sh_full > 11'd26) ? 5'd26 : sh_full[4:0];
  end

  float_denorm u_denorm (
    .data_in  ({bus.man_in, bus.round_bit, bus.sticky_bit}),
    .shamt    (shamt),
    .data_out (dn_out)
  );
`endif

  always_comb begin
    s1_d.man  = bus.man_in;
    s1_d.r    = bus.round_bit;
    s1_d.s    = bus.sticky_bit;
    s1_d.e    = e_bias;
    s1_d.sgn  = bus.sgn_in;
    s1_d.rm   = decode_rm(bus.rm);
    s1_d.skip = bus.skip_round;
    s1_d.iv   = bus.IV;
    s1_d.dz   = bus.DZ;
    s1_d.tiny = 1'b0;
    if (bus.skip_round) begin
      // Specials keep the raw 8-bit exponent field for verbatim packing.
      s1_d.e = {3'b000, bus.exp_in[7:0]};
    end else if (tiny_in) begin
`ifdef FLOAT_ROUND_SUBNORMAL_EN
      {s1_d.man, s1_d.r, s1_d.s} = dn_out;
`endif
      s1_d.e    = '0;
      s1_d.tiny = 1'b1;
    end
  end

  // ---- stage 2: round, handle carry/overflow, pack ----
  logic               inc;
  logic [24:0]        m25;
  logic [23:0]        mant;
  logic signed [10:0] e_adj;
  logic [7:0]         exp_field;
  logic               inexact;
  logic               ovf;

  always_comb begin
    inc       = round_inc(s1_p1.rm, s1_p1.sgn, s1_p1.man[0], s1_p1.r, s1_p1.s);
    m25       = {1'b0, s1_p1.man} + {24'd0, inc};
    mant      = m25[24] ? m25[24:1] : m25[23:0];
    e_adj     = s1_p1.e + (m25[24] ? 11'sd1 : 11'sd0);
    inexact   = s1_p1.r | s1_p1.s;
    ovf       = (e_adj >= $signed(11'(EXP_MAX)));
    // A subnormal that rounds up to the hidden bit becomes the smallest normal.
    exp_field = !mant[23] ? 8'd0 : ((e_adj == 11'sd0) ? 8'd1 : e_adj[7:0]);

    flags_d          = '0;
    flags_d[FLAG_NV] = s1_p1.iv;
    flags_d[FLAG_DZ] = s1_p1.dz;

    if (s1_p1.skip) begin
      float_d = {s1_p1.sgn, s1_p1.e[7:0], s1_p1.man[22:0]};
`ifndef FLOAT_ROUND_SUBNORMAL_EN
    end else if (s1_p1.tiny) begin
      float_d          = {s1_p1.sgn, 31'd0};
      flags_d[FLAG_UF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
`endif
    end else if (ovf) begin
      float_d = ovf_to_max(s1_p1.rm, s1_p1.sgn) ? {s1_p1.sgn, 8'hFE, 23'h7F_FFFF}
                                                : {s1_p1.sgn, 8'hFF, 23'h00_0000};
      flags_d[FLAG_OF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end else begin
      float_d          = {s1_p1.sgn, exp_field, mant[22:0]};
      flags_d[FLAG_NX] = inexact;
      flags_d[FLAG_UF] = s1_p1.tiny & inexact;
    end
  end

  // ---- pipeline registers: both stages advance together ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      s1_p1    <= '0;
      vld_p2   <= 1'b0;
      float_p2 <= '0;
      flags_p2 <= '0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      s1_p1    <= '0;
      vld_p2   <= 1'b0;
      float_p2 <= '0;
      flags_p2 <= '0;
    end else if (adv) begin
      vld_p1   <= bus.valid_in;
      s1_p1    <= s1_d;
      vld_p2   <= vld_p1;
      float_p2 <= float_d;
      flags_p2 <= flags_d;
    end
  end

endmodule

// File: tb/tb_float_round.sv
// Self-checking bench for float_round: directed rounding cases, latency,
// back-to-back streaming with stall, flush and asynchronous reset.
module tb_float_round;
  import float_round_pkg::*;

  typedef struct {
    string       name;
    logic [23:0] man;
    logic [9:0]  exp;
    logic        sgn;
    logic        r;
    logic        s;
    logic [2:0]  rm;
    logic        skip;
    logic        iv;
    logic        dz;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  float_round_if bus ();

  float_round dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  function automatic vec_t mk(string name, logic [23:0] man, logic [9:0] exp,
                              logic sgn, logic r, logic s, logic [2:0] rm,
                              logic skip, logic iv, logic dz,
                              logic [31:0] res, logic [4:0] fl);
    vec_t v;
    v.name = name; v.man = man; v.exp = exp; v.sgn = sgn; v.r = r; v.s = s;
    v.rm = rm; v.skip = skip; v.iv = iv; v.dz = dz; v.res = res; v.fl = fl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.man_in     = v.man;
    bus.exp_in     = v.exp;
    bus.sgn_in     = v.sgn;
    bus.round_bit  = v.r;
    bus.sticky_bit = v.s;
    bus.rm         = v.rm;
    bus.skip_round = v.skip;
    bus.IV         = v.iv;
    bus.DZ         = v.dz;
    bus.valid_in   = 1'b1;
    sb.push_back('{res: v.res, fl: v.fl});
  endtask

  task automatic idle_inputs();
    bus.valid_in   = 1'b0;
    bus.man_in     = '0;
    bus.exp_in     = '0;
    bus.sgn_in     = 1'b0;
    bus.round_bit  = 1'b0;
    bus.sticky_bit = 1'b0;
    bus.rm         = '0;
    bus.skip_round = 1'b0;
    bus.IV         = 1'b0;
    bus.DZ         = 1'b0;
  endtask

  task automatic build_vectors();
    vecs.push_back(mk("basic_1p5",    24'hC00000, 10'h000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h3FC00000, 5'h00));
    vecs.push_back(mk("carry_rne",    24'hFFFFFF, 10'h000, 0, 1, 0, 3'b000, 0, 0, 0, 32'h40000000, 5'h01));
    vecs.push_back(mk("carry_rtz",    24'hFFFFFF, 10'h000, 0, 1, 0, 3'b001, 0, 0, 0, 32'h3FFFFFFF, 5'h01));
    vecs.push_back(mk("ovf_rne",      24'h800000, 10'h080, 0, 0, 0, 3'b000, 0, 0, 0, 32'h7F800000, 5'h05));
    vecs.push_back(mk("ovf_rtz",      24'h800000, 10'h080, 0, 0, 0, 3'b001, 0, 0, 0, 32'h7F7FFFFF, 5'h05));
    vecs.push_back(mk("ovf_neg_rup",  24'h800000, 10'h080, 1, 0, 0, 3'b011, 0, 0, 0, 32'hFF7FFFFF, 5'h05));
    vecs.push_back(mk("ovf_neg_rne",  24'h800000, 10'h080, 1, 0, 0, 3'b000, 0, 0, 0, 32'hFF800000, 5'h05));
    vecs.push_back(mk("ovf_by_carry", 24'hFFFFFF, 10'h07F, 0, 1, 0, 3'b000, 0, 0, 0, 32'h7F800000, 5'h05));
    vecs.push_back(mk("rdn_neg",      24'h800000, 10'h000, 1, 0, 1, 3'b010, 0, 0, 0, 32'hBF800001, 5'h01));
    vecs.push_back(mk("rup_neg",      24'h800000, 10'h000, 1, 1, 0, 3'b011, 0, 0, 0, 32'hBF800000, 5'h01));
    vecs.push_back(mk("rmm_tie",      24'h800000, 10'h000, 0, 1, 0, 3'b100, 0, 0, 0, 32'h3F800001, 5'h01));
    vecs.push_back(mk("rne_tie_even", 24'h800000, 10'h000, 0, 1, 0, 3'b000, 0, 0, 0, 32'h3F800000, 5'h01));
    vecs.push_back(mk("rm_reserved",  24'h800001, 10'h000, 0, 1, 0, 3'b111, 0, 0, 0, 32'h3F800002, 5'h01));
    vecs.push_back(mk("skip_nan_iv",  24'hC00000, 10'h0FF, 0, 0, 0, 3'b000, 1, 1, 0, CANON_NAN,    5'h10));
    vecs.push_back(mk("skip_inf_dz",  24'h000000, 10'h0FF, 1, 1, 1, 3'b000, 1, 0, 1, 32'hFF800000, 5'h08));
`ifdef FLOAT_ROUND_SUBNORMAL_EN
    vecs.push_back(mk("sub_exact",    24'h800000, 10'h381, 0, 0, 0, 3'b000, 0, 0, 0, 32'h00400000, 5'h00));
    vecs.push_back(mk("sub_rup",      24'h800000, 10'h381, 0, 1, 0, 3'b011, 0, 0, 0, 32'h00400001, 5'h03));
    vecs.push_back(mk("sub_to_norm",  24'hFFFFFF, 10'h381, 0, 0, 0, 3'b000, 0, 0, 0, 32'h00800000, 5'h03));
    vecs.push_back(mk("deep_tiny",    24'h800000, 10'h338, 0, 0, 0, 3'b011, 0, 0, 0, 32'h00000001, 5'h03));
`else
    vecs.push_back(mk("ftz_exact",    24'h800000, 10'h381, 0, 0, 0, 3'b000, 0, 0, 0, 32'h00000000, 5'h03));
    vecs.push_back(mk("ftz_rup",      24'h800000, 10'h381, 0, 1, 0, 3'b011, 0, 0, 0, 32'h00000000, 5'h03));
    vecs.push_back(mk("ftz_neg",      24'hFFFFFF, 10'h381, 1, 0, 0, 3'b000, 0, 0, 0, 32'h80000000, 5'h03));
    vecs.push_back(mk("ftz_deep",     24'h800000, 10'h338, 0, 0, 0, 3'b011, 0, 0, 0, 32'h00000000, 5'h03));
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; bus.ready_in = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid_out); end
    n_checks++; if (bus.float_out !== 32'h0) begin n_fail++; $display("FAIL reset_float got %h want 00000000", bus.float_out); end
    n_checks++; if (bus.fflags !== 5'h0) begin n_fail++; $display("FAIL reset_flags got %h want 00", bus.fflags); end
    n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.ready_out); end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    exp_t e;
    @(posedge clk); #1;
    drive(vecs[0]);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL latency_early got %b want 0", bus.valid_out); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b want 1", bus.valid_out); end
    e = sb.pop_front();
    n_checks++; if (bus.float_out !== e.res) begin n_fail++; $display("FAIL latency_float got %h want %h", bus.float_out, e.res); end
    n_checks++; if (bus.fflags !== e.fl) begin n_fail++; $display("FAIL latency_flags got %h want %h", bus.fflags, e.fl); end
  endtask

  task automatic test_directed();
    exp_t e;
    bit   got;
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (bus.valid_out) begin
          got = 1'b1;
          e = sb.pop_front();
          n_checks++;
          if (bus.float_out !== e.res) begin n_fail++; $display("FAIL %s float_out got %h want %h", vecs[i].name, bus.float_out, e.res); end
          n_checks++;
          if (bus.fflags !== e.fl) begin n_fail++; $display("FAIL %s fflags got %h want %h", vecs[i].name, bus.fflags, e.fl); end
        end
      end
      if (!got) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout got no valid_out want one result", vecs[i].name);
        sb.delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    @(posedge clk); #1;
    fork
      begin
        bit acc;
        for (int k = 0; k < 4; k++) begin
          drive(vecs[k]);
          acc = 1'b0;
          for (int w = 0; w < 20 && !acc; w++) begin
            @(negedge clk);
            acc = bus.ready_out;
            @(posedge clk); #1;
          end
          if (!acc) begin n_checks++; n_fail++; $display("FAIL b2b_accept_timeout item %0d got no accept want accept", k); end
        end
        bus.valid_in = 1'b0;
      end
      begin
        exp_t e;
        for (int cyc = 0; cyc < 20; cyc++) begin
          @(posedge clk); #1;
          bus.ready_in = !(cyc >= 3 && cyc < 6);
          @(negedge clk);
          if (bus.valid_out && !bus.ready_in) begin
            n_checks++;
            if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready got %b want 0", bus.ready_out); end
          end
          if (bus.valid_out && bus.ready_in) begin
            n_checks++;
            if (sb.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra got output %h want none", bus.float_out);
            end else begin
              e = sb.pop_front();
              got++;
              if (bus.float_out !== e.res || bus.fflags !== e.fl) begin
                n_fail++;
                $display("FAIL b2b_order got %h/%h want %h/%h", bus.float_out, bus.fflags, e.res, e.fl);
              end
            end
          end
        end
      end
    join
    bus.ready_in = 1'b1;
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", got); end
    sb.delete();
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus.ready_in = 1'b0;
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    @(posedge clk); #1;
    drive(vecs[2]);
    @(negedge clk);
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_full_valid got %b want 1", bus.valid_out); end
    n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL flush_full_ready got %b want 0", bus.ready_out); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.valid_in = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", bus.valid_out); end
    n_checks++; if (bus.float_out !== 32'h0) begin n_fail++; $display("FAIL flush_float got %h want 00000000", bus.float_out); end
    n_checks++; if (bus.fflags !== 5'h0) begin n_fail++; $display("FAIL flush_flags got %h want 00", bus.fflags); end
    sb.delete();
    // flush wins over an input offered in the same cycle
    bus.ready_in = 1'b1;
    drive(vecs[3]);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.valid_in = 1'b0;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.valid_out) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL flush_priority got valid_out want none"); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus.ready_in = 1'b0;
    drive(vecs[4]);
    @(posedge clk); #1;
    drive(vecs[5]);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_full got %b want 1", bus.valid_out); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_valid got %b want 0", bus.valid_out); end
    n_checks++; if (bus.float_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_async_float got %h want 00000000", bus.float_out); end
    @(negedge clk);
    reset = 1'b0;
    bus.ready_in = 1'b1;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.valid_out) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rstmid_drop got valid_out want none"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_vectors();
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
